// File: rtl/ring_meter_pkg.sv
// Shared definitions for the ring-oscillator measurement sequencer:
// FSM state encoding and default parameter values.
package ring_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meter_state_t;

  localparam int unsigned DEF_CNT_W         = 16;
  localparam int unsigned DEF_GATE_W        = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector. The pulse is one clock wide and appears three clocks
// after the input is first sampled high.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronizer chain, previous-value register and registered edge pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/ring_osc_meter_ctrl.sv
// Measurement sequencer for the ring-oscillator/divider macro. Enables the
// oscillator, waits a settle interval, counts synchronized rising edges of
// the divided output over a programmable gate, then reports the count with
// a one-cycle done pulse. The oscillator only runs during SETTLE/MEASURE.
module ring_osc_meter_ctrl
  import ring_meter_pkg::*;
#(
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned GATE_W        = DEF_GATE_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_en1,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              div_in,
  output logic              osc_en,
  output logic              osc_en1,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  // One down-counter serves both the settle and the gate interval, so it is
  // sized for whichever of the two needs more bits.
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;

  meter_state_t      state;
  logic [TMR_W-1:0]  tmr;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  acc;
  logic              acc_ovf;
  logic [CNT_W-1:0]  acc_next;
  logic              ovf_next;
  logic              edge_pulse;

  sync_edge_detect u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (div_in),
    .pulse (edge_pulse)
  );

  // Saturating accumulator update for the current edge pulse
  always_comb begin
    acc_next = acc;
    ovf_next = acc_ovf;
    if (edge_pulse) begin
      if (acc == '1) begin
        ovf_next = 1'b1;
      end else begin
        acc_next = acc + 1'b1;
      end
    end
  end

  // Sequencer FSM with registered enables, status and result outputs.
  // The final MEASURE cycle's pulse is folded into the result through
  // acc_next, so count loads on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tmr      <= '0;
      gate_q   <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      osc_en   <= 1'b0;
      osc_en1  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          osc_en  <= 1'b0;
          osc_en1 <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (gate_len != '0) begin
              gate_q  <= gate_len;
              tmr     <= TMR_W'(SETTLE_CYCLES - 1);
              acc     <= '0;
              acc_ovf <= 1'b0;
              osc_en  <= 1'b1;
              osc_en1 <= cfg_en1;
              state   <= ST_SETTLE;
            end else begin
              count    <= '0;
              overflow <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            osc_en  <= 1'b0;
            osc_en1 <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            if (tmr == '0) begin
              tmr   <= TMR_W'(gate_q) - TMR_W'(1);
              state <= ST_MEASURE;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
        end

        ST_MEASURE: begin
          if (abort) begin
            osc_en  <= 1'b0;
            osc_en1 <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            acc     <= acc_next;
            acc_ovf <= ovf_next;
            if (tmr == '0) begin
              count    <= acc_next;
              overflow <= ovf_next;
              done     <= 1'b1;
              osc_en   <= 1'b0;
              osc_en1  <= 1'b0;
              state    <= ST_DONE;
            end else begin
              tmr <= tmr - 1'b1;
            end
          end
        end

        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_meter_ctrl.sv
// Self-checking bench for ring_osc_meter_ctrl. A default-width instance and
// a CNT_W=4 instance share all inputs. A cycle-indexed behavioural model
// derives every output from the start/abort/reset history and the sampled
// div_in record; directed scenarios add literal expectations.
module tb_ring_osc_meter_ctrl;

  localparam int S      = 16;
  localparam int GW     = 16;
  localparam int HIST_N = 32768;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          cfg_en1;
  logic [GW-1:0] gate_len;
  logic          div_in;

  logic          osc_en_a, osc_en1_a, busy_a, done_a, ovf_a;
  logic [15:0]   count_a;
  logic          osc_en_b, osc_en1_b, busy_b, done_b, ovf_b;
  logic [3:0]    count_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ring_osc_meter_ctrl #(.CNT_W(16), .GATE_W(GW), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_en1(cfg_en1),
    .gate_len(gate_len), .div_in(div_in), .osc_en(osc_en_a), .osc_en1(osc_en1_a),
    .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a)
  );

  ring_osc_meter_ctrl #(.CNT_W(4), .GATE_W(GW), .SETTLE_CYCLES(S)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_en1(cfg_en1),
    .gate_len(gate_len), .div_in(div_in), .osc_en(osc_en_b), .osc_en1(osc_en1_b),
    .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle time %0t)", name, act, exp, $time);
  endtask

  // ---------------- div_in generator (changes away from posedge) ----------
  int          div_mode = 0;
  int unsigned ph = 0;
  always @(negedge clk) begin
    ph <= ph + 1;
    case (div_mode)
      1:       div_in <= ph[2];
      2:       div_in <= ph[0];
      3:       div_in <= 1'($urandom_range(0, 1));
      default: div_in <= 1'b0;
    endcase
  end

  // ---------------- behavioural model ------------------------------------
  int   cyc = 0;
  logic samp [0:HIST_N-1];
  bit   m_act = 0;
  int   m_e0 = 0, m_g = 0, m_end = 0;
  bit   m_cfg = 0;
  bit   e_busy = 0, e_en = 0, e_en1 = 0, e_done = 0;
  int   e_cnt = 0, e_cnt4 = 0;
  bit   e_ovf = 0, e_ovf4 = 0;

  // Rising edges of the sampled input whose detected pulse (3 edges later)
  // falls inside one of the G measurement cycles.
  function automatic int edges_in(input int e0, input int g);
    int n = 0;
    for (int k = e0 + S - 2; k <= e0 + S + g - 3; k++)
      if (k >= 1 && k < HIST_N && samp[k] === 1'b1 && samp[k-1] !== 1'b1) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    bit idle_before;
    int n;
    cyc = cyc + 1;
    if (cyc < HIST_N) samp[cyc] = (rst_n === 1'b1) ? div_in : 1'b0;
    if (rst_n !== 1'b1) begin
      m_act = 0;
      e_cnt = 0; e_ovf = 0; e_cnt4 = 0; e_ovf4 = 0;
    end else begin
      idle_before = !(m_act && (cyc - 1) <= m_end);
      if (!idle_before) begin
        if (abort && (cyc - 1) < m_end) m_act = 0;
      end else if (start) begin
        m_act = 1; m_e0 = cyc; m_g = int'(gate_len); m_cfg = cfg_en1;
        m_end = (m_g == 0) ? cyc : cyc + S + m_g;
      end
    end
    e_busy = m_act && cyc <= m_end;
    e_en   = m_act && m_g != 0 && cyc < m_end;
    e_en1  = e_en && m_cfg;
    e_done = m_act && cyc == m_end;
    if (e_done) begin
      n = (m_g == 0) ? 0 : edges_in(m_e0, m_g);
      e_cnt  = (n > 65535) ? 65535 : n;  e_ovf  = n > 65535;
      e_cnt4 = (n > 15)    ? 15    : n;  e_ovf4 = n > 15;
    end
  end

  // ---------------- per-cycle compare against the model -------------------
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("busy",       busy_a,    e_busy);
      check("osc_en",     osc_en_a,  e_en);
      check("osc_en1",    osc_en1_a, e_en1);
      check("done",       done_a,    e_done);
      check("count",      count_a,   e_cnt);
      check("overflow",   ovf_a,     e_ovf);
      check("w4_busy",    busy_b,    e_busy);
      check("w4_osc_en",  osc_en_b,  e_en);
      check("w4_done",    done_b,    e_done);
      check("w4_count",   count_b,   e_cnt4);
      check("w4_overflow", ovf_b,    e_ovf4);
    end
  end

  int en_cycles = 0;
  always @(negedge clk) if (osc_en_a === 1'b1) en_cycles <= en_cycles + 1;

  // ---------------- stimulus helpers --------------------------------------
  task automatic start_meas(input int g, input bit cfg, output int e0);
    @(negedge clk);
    gate_len = GW'(g); cfg_en1 = cfg; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) at = cyc;
    end
    if (at < 0) check("done_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    int e0, at;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_en1 = 1'b0; gate_len = '0;
    div_in = 1'b0;
    idle_cycles(3);
    check("rst_busy", busy_a, 0);
    check("rst_count", count_a, 0);
    check("rst_osc_en", osc_en_a, 0);
    rst_n = 1'b1;
    idle_cycles(2);

    // Idle input, gate 50, with a stray start mid-run
    div_mode = 0;
    en_cycles = 0;
    start_meas(50, 0, e0);
    idle_cycles(20);
    gate_len = 16'd5; start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(200, at);
    check("t1_latency", at - e0, 66);
    check("t1_count", count_a, 0);
    check("t1_overflow", ovf_a, 0);
    check("t1_en_cycles", en_cycles, 66);
    idle_cycles(3);

    // Period-8 square wave, gate 64, cfg_en1=1
    div_mode = 1;
    idle_cycles(10);
    start_meas(64, 1, e0);
    check("t2_en1", osc_en1_a, 1);
    wait_done(200, at);
    check("t2_count", count_a, 8);
    check("t2_overflow", ovf_a, 0);
    idle_cycles(3);

    // Period-2 wave, gate 100: narrow instance saturates
    div_mode = 2;
    idle_cycles(10);
    start_meas(100, 0, e0);
    wait_done(300, at);
    check("t3_count16", count_a, 50);
    check("t3_count4", count_b, 15);
    check("t3_ovf4", ovf_b, 1);
    idle_cycles(3);

    // Zero gate
    en_cycles = 0;
    start_meas(0, 1, e0);
    check("t4_done", done_a, 1);
    check("t4_count", count_a, 0);
    @(negedge clk);
    check("t4_busy_fall", busy_a, 0);
    check("t4_en_cycles", en_cycles, 0);

    // Prior run leaves count=7, then abort at MEASURE cycle 10
    div_mode = 1;
    idle_cycles(10);
    start_meas(56, 0, e0);
    wait_done(200, at);
    check("t5_prior_count", count_a, 7);
    idle_cycles(3);
    start_meas(56, 0, e0);
    while (cyc < e0 + S + 10) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("t5_abort_busy", busy_a, 0);
    check("t5_abort_en", osc_en_a, 0);
    check("t5_abort_count", count_a, 7);
    at = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) at = 1;
    end
    check("t5_no_done", at, 0);

    // Reset during SETTLE, then a normal run
    start_meas(30, 1, e0);
    idle_cycles(3);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    check("t6_rst_count", count_a, 0);
    check("t6_rst_busy", busy_a, 0);
    check("t6_rst_en", osc_en_a, 0);
    check("t6_rst_en1", osc_en1_a, 0);
    idle_cycles(3);
    start_meas(20, 1, e0);
    wait_done(100, at);
    check("t6_latency", at - e0, 36);
    idle_cycles(3);

    // Randomized traffic checked by the model
    for (int t = 0; t < 40; t++) begin
      int g, win;
      div_mode = $urandom_range(0, 3);
      g = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 60);
      start_meas(g, 1'($urandom_range(0, 1)), e0);
      win = S + g + 4;
      for (int i = 0; i < win; i++) begin
        @(negedge clk);
        abort = ($urandom_range(0, 63) == 0);
        start = ($urandom_range(0, 7) == 0);
        gate_len = GW'($urandom_range(0, 40));
      end
      abort = 1'b0; start = 1'b0;
      for (int i = 0; i < 200 && busy_a === 1'b1; i++) @(negedge clk);
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
